// File: rtl/ptw_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ptw_req_scheduler
// Description : Round-robin, one-outstanding scheduler that lets N_REQ
//               requesters (I-TLB, D-TLB, prefetcher, ...) share a single
//               page-table-walker port. It grants one request, holds it on
//               the walker channel until it is accepted, then waits for the
//               walker response and steers the response strobe back to the
//               requester that issued it.
// Ports       :
//   clock              - single clock, all state on rising edge
//   reset              - asynchronous active-low reset
//   io_in_valid        - per-requester request valid           [N_REQ]
//   io_in_addr         - per-requester VPN, slice i at i*ADDR_W [N_REQ*ADDR_W]
//   io_in_ready        - one-hot grant, combinational in IDLE  [N_REQ]
//   io_out_valid       - request to walker (SEND state)
//   io_out_addr        - registered granted address            [ADDR_W]
//   io_out_src         - registered granted source index       [SRC_W]
//   io_out_ready       - walker accepts request
//   io_resp_valid      - walker response strobe
//   io_resp_bits       - walker response payload               [RESP_W]
//   io_resp_out_valid  - one-hot response strobe to the owner  [N_REQ]
//   io_resp_out_bits   - response payload passthrough          [RESP_W]
//   io_busy            - high in SEND or WAIT (registered state decode)
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_req_scheduler #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 27,
    parameter int RESP_W = 64,
    parameter int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          io_in_valid,
    input  logic [N_REQ*ADDR_W-1:0]   io_in_addr,
    output logic [N_REQ-1:0]          io_in_ready,
    output logic                      io_out_valid,
    output logic [ADDR_W-1:0]         io_out_addr,
    output logic [SRC_W-1:0]          io_out_src,
    input  logic                      io_out_ready,
    input  logic                      io_resp_valid,
    input  logic [RESP_W-1:0]         io_resp_bits,
    output logic [N_REQ-1:0]          io_resp_out_valid,
    output logic [RESP_W-1:0]         io_resp_out_bits,
    output logic                      io_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Pointer resets to the last requester so that requester 0 wins first.
    localparam logic [SRC_W-1:0] C_PTR_RST = SRC_W'(N_REQ - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SRC_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]   r_addr;
    logic [SRC_W-1:0]    r_src;

    logic                w_found;
    logic [SRC_W-1:0]    w_winner;
    logic [SRC_W-1:0]    w_sel;
    logic                w_grant;
    logic [ADDR_W-1:0]   w_addr_arr [N_REQ];

    // Unpack the flat address bus so the winner can be selected by index.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr_slice
            assign w_addr_arr[gi] = io_in_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Round-robin search: visit ptr+1, ptr+2, ... ptr+N_REQ (mod N_REQ) and
    // take the first valid one. The modulo keeps the wrap correct for
    // non-power-of-two requester counts.
    always_comb begin : p_rr_pick
        w_found  = 1'b0;
        w_winner = '0;
        w_sel    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_sel = SRC_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && io_in_valid[w_sel]) begin
                w_found  = 1'b1;
                w_winner = w_sel;
            end
        end
    end

    assign w_grant = (r_state == ST_IDLE) && w_found;

    // Next-state logic
    always_comb begin : p_fsm_nxt
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_found)       w_state_nxt = ST_SEND;
            ST_SEND: if (io_out_ready)  w_state_nxt = ST_WAIT;
            ST_WAIT: if (io_resp_valid) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin : p_fsm_reg
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture and round-robin pointer; both move only on a grant.
    always_ff @(posedge clock or negedge reset) begin : p_req_reg
        if (!reset) begin
            r_addr <= '0;
            r_src  <= '0;
            r_ptr  <= C_PTR_RST;
        end else if (w_grant) begin
            r_addr <= w_addr_arr[w_winner];
            r_src  <= w_winner;
            r_ptr  <= w_winner;
        end
    end

    // One-hot grant and response steering. The grant is a combinational path
    // from io_in_valid, so it is also masked by reset to keep every output
    // low while reset is held.
    always_comb begin : p_onehot
        io_in_ready       = '0;
        io_resp_out_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (reset && w_grant && (w_winner == SRC_W'(i))) begin
                io_in_ready[i] = 1'b1;
            end
            if ((r_state == ST_WAIT) && io_resp_valid && (r_src == SRC_W'(i))) begin
                io_resp_out_valid[i] = 1'b1;
            end
        end
    end

    assign io_out_valid     = (r_state == ST_SEND);
    assign io_out_addr      = r_addr;
    assign io_out_src       = r_src;
    assign io_resp_out_bits = io_resp_bits;
    assign io_busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ptw_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptw_req_scheduler
// Description : Directed self-checking bench for ptw_req_scheduler with
//               three requesters. Inputs are driven on the falling edge and
//               outputs sampled 1 ns later, away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptw_req_scheduler;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 27;
    localparam int RESP_W = 64;
    localparam int SRC_W  = 2;

    logic                    clock;
    logic                    reset;
    logic [N_REQ-1:0]        io_in_valid;
    logic [N_REQ*ADDR_W-1:0] io_in_addr;
    logic [N_REQ-1:0]        io_in_ready;
    logic                    io_out_valid;
    logic [ADDR_W-1:0]       io_out_addr;
    logic [SRC_W-1:0]        io_out_src;
    logic                    io_out_ready;
    logic                    io_resp_valid;
    logic [RESP_W-1:0]       io_resp_bits;
    logic [N_REQ-1:0]        io_resp_out_valid;
    logic [RESP_W-1:0]       io_resp_out_bits;
    logic                    io_busy;

    int n_checks;
    int n_fail;

    ptw_req_scheduler #(
        .N_REQ (N_REQ),
        .ADDR_W(ADDR_W),
        .RESP_W(RESP_W),
        .SRC_W (SRC_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_valid      (io_in_valid),
        .io_in_addr       (io_in_addr),
        .io_in_ready      (io_in_ready),
        .io_out_valid     (io_out_valid),
        .io_out_addr      (io_out_addr),
        .io_out_src       (io_out_src),
        .io_out_ready     (io_out_ready),
        .io_resp_valid    (io_resp_valid),
        .io_resp_bits     (io_resp_bits),
        .io_resp_out_valid(io_resp_out_valid),
        .io_resp_out_bits (io_resp_out_bits),
        .io_busy          (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset         = 1'b0;
        io_in_valid   = 3'b111;
        io_in_addr    = '1;
        io_out_ready  = 1'b1;
        io_resp_valid = 1'b1;
        io_resp_bits  = '0;
        @(negedge clock); #1;
        n_checks++; if (io_in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 000", io_in_ready); end
        n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", io_out_valid); end
        n_checks++; if (io_out_addr !== 27'h0) begin n_fail++; $display("FAIL reset_out_addr: got %h want 0", io_out_addr); end
        n_checks++; if (io_out_src !== 2'd0) begin n_fail++; $display("FAIL reset_out_src: got %0d want 0", io_out_src); end
        n_checks++; if (io_resp_out_valid !== 3'b000) begin n_fail++; $display("FAIL reset_resp_out_valid: got %b want 000", io_resp_out_valid); end
        n_checks++; if (io_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", io_busy); end
        @(negedge clock);
        io_in_valid   = 3'b000;
        io_resp_valid = 1'b0;
        reset         = 1'b1;
    endtask

    task automatic test_single;
        @(negedge clock);
        io_in_valid = 3'b010;
        io_in_addr  = '0;
        io_in_addr[1*ADDR_W +: ADDR_W] = 27'h1234567;
        io_out_ready = 1'b1;
        #1;
        n_checks++; if (io_in_ready !== 3'b010) begin n_fail++; $display("FAIL single_grant: got %b want 010", io_in_ready); end
        n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_out_valid: got %b want 0", io_out_valid); end
        @(negedge clock);
        io_in_valid = 3'b000;
        #1;
        n_checks++; if (io_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_send_valid: got %b want 1", io_out_valid); end
        n_checks++; if (io_out_addr !== 27'h1234567) begin n_fail++; $display("FAIL single_send_addr: got %h want 1234567", io_out_addr); end
        n_checks++; if (io_out_src !== 2'd1) begin n_fail++; $display("FAIL single_send_src: got %0d want 1", io_out_src); end
        n_checks++; if (io_busy !== 1'b1) begin n_fail++; $display("FAIL single_send_busy: got %b want 1", io_busy); end
        @(negedge clock); #1;
        n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_wait_out_valid: got %b want 0", io_out_valid); end
        n_checks++; if (io_busy !== 1'b1) begin n_fail++; $display("FAIL single_wait_busy: got %b want 1", io_busy); end
        @(negedge clock);
        io_resp_valid = 1'b1;
        io_resp_bits  = 64'hDEAD;
        #1;
        n_checks++; if (io_resp_out_valid !== 3'b010) begin n_fail++; $display("FAIL single_resp_valid: got %b want 010", io_resp_out_valid); end
        n_checks++; if (io_resp_out_bits !== 64'hDEAD) begin n_fail++; $display("FAIL single_resp_bits: got %h want dead", io_resp_out_bits); end
        @(negedge clock);
        io_resp_valid = 1'b0;
        #1;
        n_checks++; if (io_busy !== 1'b0) begin n_fail++; $display("FAIL single_back_idle: got %b want 0", io_busy); end
    endtask

    task automatic test_fairness;
        logic [2:0] exp_oh;
        int         exp_idx;
        do_reset();
        for (int i = 0; i < N_REQ; i++) io_in_addr[i*ADDR_W +: ADDR_W] = 27'h100 + 27'(i);
        io_out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            exp_idx = r % 3;
            exp_oh  = 3'b001 << exp_idx;
            @(negedge clock);
            io_resp_valid = 1'b0;
            io_in_valid   = 3'b111;
            #1;
            n_checks++; if (io_in_ready !== exp_oh) begin n_fail++; $display("FAIL fair_grant_%0d: got %b want %b", r, io_in_ready, exp_oh); end
            @(negedge clock); #1;
            n_checks++; if (io_out_src !== 2'(exp_idx) || io_out_valid !== 1'b1) begin n_fail++; $display("FAIL fair_src_%0d: got %0d/v%b want %0d/v1", r, io_out_src, io_out_valid, exp_idx); end
            n_checks++; if (io_out_addr !== 27'h100 + 27'(exp_idx)) begin n_fail++; $display("FAIL fair_addr_%0d: got %h want %h", r, io_out_addr, 27'h100 + 27'(exp_idx)); end
            @(negedge clock);
            io_resp_valid = 1'b1;
            io_resp_bits  = 64'(r);
            #1;
            n_checks++; if (io_resp_out_valid !== exp_oh) begin n_fail++; $display("FAIL fair_resp_%0d: got %b want %b", r, io_resp_out_valid, exp_oh); end
        end
        @(negedge clock);
        io_resp_valid = 1'b0;
        io_in_valid   = 3'b000;
        #1;
        n_checks++; if (io_busy !== 1'b0) begin n_fail++; $display("FAIL fair_end_idle: got %b want 0", io_busy); end
    endtask

    task automatic test_backpressure;
        @(negedge clock);
        io_in_valid  = 3'b100;
        io_in_addr[2*ADDR_W +: ADDR_W] = 27'h5A5A5A5;
        io_out_ready = 1'b0;
        #1;
        n_checks++; if (io_in_ready !== 3'b100) begin n_fail++; $display("FAIL bp_grant: got %b want 100", io_in_ready); end
        for (int b = 0; b < 5; b++) begin
            @(negedge clock);
            io_in_valid = 3'b111;
            io_in_addr[2*ADDR_W +: ADDR_W] = 27'h0F0F0F0 + 27'(b);
            #1;
            n_checks++; if (io_out_valid !== 1'b1 || io_out_addr !== 27'h5A5A5A5 || io_out_src !== 2'd2) begin
                n_fail++; $display("FAIL bp_hold_%0d: got v%b addr %h src %0d want v1 addr 5a5a5a5 src 2", b, io_out_valid, io_out_addr, io_out_src);
            end
            n_checks++; if (io_in_ready !== 3'b000) begin n_fail++; $display("FAIL bp_ready_low_%0d: got %b want 000", b, io_in_ready); end
        end
        @(negedge clock);
        io_out_ready = 1'b1;
        #1;
        n_checks++; if (io_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_handshake_valid: got %b want 1", io_out_valid); end
        @(negedge clock); #1;
        n_checks++; if (io_out_valid !== 1'b0 || io_busy !== 1'b1) begin n_fail++; $display("FAIL bp_wait: got v%b busy %b want v0 busy1", io_out_valid, io_busy); end
        @(negedge clock);
        io_resp_valid = 1'b1;
        io_in_valid   = 3'b000;
        #1;
        n_checks++; if (io_resp_out_valid !== 3'b100) begin n_fail++; $display("FAIL bp_resp: got %b want 100", io_resp_out_valid); end
        @(negedge clock);
        io_resp_valid = 1'b0;
    endtask

    task automatic test_spurious;
        @(negedge clock);
        io_resp_valid = 1'b1;
        io_in_valid   = 3'b000;
        #1;
        n_checks++; if (io_resp_out_valid !== 3'b000) begin n_fail++; $display("FAIL spur_idle_resp: got %b want 000", io_resp_out_valid); end
        @(negedge clock);
        io_resp_valid = 1'b0;
        io_in_valid   = 3'b001;
        io_out_ready  = 1'b0;
        #1;
        n_checks++; if (io_busy !== 1'b0 || io_in_ready !== 3'b001) begin n_fail++; $display("FAIL spur_idle_state: got busy %b ready %b want busy0 ready 001", io_busy, io_in_ready); end
        @(negedge clock);
        io_in_valid   = 3'b000;
        io_resp_valid = 1'b1;
        #1;
        n_checks++; if (io_resp_out_valid !== 3'b000) begin n_fail++; $display("FAIL spur_send_resp: got %b want 000", io_resp_out_valid); end
        @(negedge clock);
        io_resp_valid = 1'b0;
        #1;
        n_checks++; if (io_out_valid !== 1'b1) begin n_fail++; $display("FAIL spur_send_state: got %b want 1", io_out_valid); end
        @(negedge clock);
        io_out_ready = 1'b1;
        @(negedge clock);
        io_out_ready = 1'b0;
        #1;
        n_checks++; if (io_out_valid !== 1'b0 || io_busy !== 1'b1) begin n_fail++; $display("FAIL spur_wait: got v%b busy %b want v0 busy1", io_out_valid, io_busy); end
        @(negedge clock);
        io_resp_valid = 1'b1;
        #1;
        n_checks++; if (io_resp_out_valid !== 3'b001) begin n_fail++; $display("FAIL spur_real_resp: got %b want 001", io_resp_out_valid); end
        @(negedge clock);
        io_resp_valid = 1'b0;
        io_out_ready  = 1'b1;
    endtask

    task automatic test_reset_mid_wait;
        @(negedge clock);
        io_in_valid = 3'b010;
        #1;
        n_checks++; if (io_in_ready !== 3'b010) begin n_fail++; $display("FAIL rmw_grant: got %b want 010", io_in_ready); end
        @(negedge clock);
        io_in_valid = 3'b000;
        @(negedge clock); #1;
        n_checks++; if (io_busy !== 1'b1 || io_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_in_wait: got busy %b v%b want busy1 v0", io_busy, io_out_valid); end
        @(negedge clock);
        reset       = 1'b0;
        io_in_valid = 3'b111;
        #1;
        n_checks++; if (io_busy !== 1'b0 || io_out_valid !== 1'b0 || io_in_ready !== 3'b000) begin
            n_fail++; $display("FAIL rmw_async_ctrl: got busy %b v%b ready %b want 0 0 000", io_busy, io_out_valid, io_in_ready);
        end
        n_checks++; if (io_out_addr !== 27'h0 || io_out_src !== 2'd0 || io_resp_out_valid !== 3'b000) begin
            n_fail++; $display("FAIL rmw_async_data: got addr %h src %0d rv %b want 0 0 000", io_out_addr, io_out_src, io_resp_out_valid);
        end
        @(negedge clock);
        reset       = 1'b1;
        io_in_valid = 3'b000;
        @(negedge clock);
        io_resp_valid = 1'b1;
        #1;
        n_checks++; if (io_resp_out_valid !== 3'b000 || io_busy !== 1'b0) begin n_fail++; $display("FAIL rmw_stale_resp: got rv %b busy %b want 000 0", io_resp_out_valid, io_busy); end
        @(negedge clock);
        io_resp_valid = 1'b0;
        io_in_valid   = 3'b111;
        #1;
        n_checks++; if (io_in_ready !== 3'b001) begin n_fail++; $display("FAIL rmw_next_grant: got %b want 001", io_in_ready); end
        @(negedge clock);
        io_in_valid = 3'b000;
        @(negedge clock);
        @(negedge clock);
        io_resp_valid = 1'b1;
        @(negedge clock);
        io_resp_valid = 1'b0;
    endtask

    task automatic test_wrap;
        @(negedge clock);
        io_in_valid = 3'b100;
        #1;
        n_checks++; if (io_in_ready !== 3'b100) begin n_fail++; $display("FAIL wrap_grant2: got %b want 100", io_in_ready); end
        @(negedge clock);
        io_in_valid = 3'b000;
        @(negedge clock);
        @(negedge clock);
        io_resp_valid = 1'b1;
        #1;
        n_checks++; if (io_resp_out_valid !== 3'b100) begin n_fail++; $display("FAIL wrap_resp2: got %b want 100", io_resp_out_valid); end
        @(negedge clock);
        io_resp_valid = 1'b0;
        io_in_valid   = 3'b101;
        #1;
        n_checks++; if (io_in_ready !== 3'b001) begin n_fail++; $display("FAIL wrap_grant0: got %b want 001", io_in_ready); end
        @(negedge clock);
        io_in_valid = 3'b000;
        #1;
        n_checks++; if (io_out_src !== 2'd0 || io_out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_src0: got %0d/v%b want 0/v1", io_out_src, io_out_valid); end
        @(negedge clock);
        @(negedge clock);
        io_resp_valid = 1'b1;
        @(negedge clock);
        io_resp_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_spurious();
        test_reset_mid_wait();
        test_wrap();
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
